// File: rtl/gate_response_checker_if.sv
// Vector/response bus between a gate test driver and gate_response_checker.
// The sig signal exists only when CHECKER_SIG_EN is defined.
interface gate_response_checker_if #(
   parameter int N_IN  = 3,
   parameter int CNT_W = 8
);
   logic             start;
   logic             vec_valid;
   logic [N_IN-1:0]  vec_in;
   logic             y_in;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] vec_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic             first_err_vld;
   logic [N_IN-1:0]  first_err_vec;
`ifdef CHECKER_SIG_EN
   logic [15:0]      sig;

   modport master (
      output start, vec_valid, vec_in, y_in,
      input  busy, done, pass, vec_cnt, err_cnt, first_err_vld, first_err_vec, sig
   );
   modport slave (
      input  start, vec_valid, vec_in, y_in,
      output busy, done, pass, vec_cnt, err_cnt, first_err_vld, first_err_vec, sig
   );
`else
   modport master (
      output start, vec_valid, vec_in, y_in,
      input  busy, done, pass, vec_cnt, err_cnt, first_err_vld, first_err_vec
   );
   modport slave (
      input  start, vec_valid, vec_in, y_in,
      output busy, done, pass, vec_cnt, err_cnt, first_err_vld, first_err_vec
   );
`endif
endinterface

// File: rtl/gate_response_checker.sv
// Checks gate outputs against a golden truth table over NUM_VEC vectors; counts and records mismatches.
// Optional CRC-CCITT response signature when CHECKER_SIG_EN is defined.
module gate_response_checker #(
   parameter int                   N_IN    = 3,
   parameter logic [(1<<N_IN)-1:0] TRUTH   = 8'h80,
   parameter int                   NUM_VEC = 8,
   parameter int                   CNT_W   = 8
) (
   input logic                   clk,
   input logic                   rst_n,
   gate_response_checker_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VEC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t           state_q;
   logic             busy_q;
   logic             done_q;
   logic [CNT_W-1:0] vec_cnt_q;
   logic [CNT_W-1:0] err_cnt_q;
   logic [CNT_W-1:0] err_cnt_d;
   logic             first_err_vld_q;
   logic [N_IN-1:0]  first_err_vec_q;

   logic start_take;
   logic accept;
   logic mismatch;
   logic last_vec;

   assign start_take = bus.start && (state_q != ST_RUN);
   assign accept     = (state_q == ST_RUN) && bus.vec_valid;
   assign mismatch   = bus.y_in != TRUTH[bus.vec_in];
   assign last_vec   = vec_cnt_q == LAST_CNT;

   // Saturating error count; stays at CNT_MAX rather than wrapping.
   assign err_cnt_d = (mismatch && (err_cnt_q != CNT_MAX)) ? err_cnt_q + 1'b1 : err_cnt_q;

`ifdef CHECKER_SIG_EN
   logic [15:0] sig_q;
   logic [15:0] sig_d;
   logic        sig_fb;

   assign sig_fb = sig_q[15] ^ bus.y_in;
   assign sig_d  = {sig_q[14:0], 1'b0} ^ (sig_fb ? 16'h1021 : 16'h0000);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= 16'h0000;
      end else if (start_take) begin
         sig_q <= 16'hFFFF;
      end else if (accept) begin
         sig_q <= sig_d;
      end
   end

   assign bus.sig = sig_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         vec_cnt_q       <= '0;
         err_cnt_q       <= '0;
         first_err_vld_q <= 1'b0;
         first_err_vec_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               // A vector arriving with start is dropped: the run has not begun yet.
               if (bus.start) begin
                  state_q         <= ST_RUN;
                  busy_q          <= 1'b1;
                  done_q          <= 1'b0;
                  vec_cnt_q       <= '0;
                  err_cnt_q       <= '0;
                  first_err_vld_q <= 1'b0;
                  first_err_vec_q <= '0;
               end
            end
            ST_RUN: begin
               if (bus.vec_valid) begin
                  vec_cnt_q <= vec_cnt_q + 1'b1;
                  err_cnt_q <= err_cnt_d;
                  if (mismatch && !first_err_vld_q) begin
                     first_err_vld_q <= 1'b1;
                     first_err_vec_q <= bus.vec_in;
                  end
                  if (last_vec) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.pass          = done_q && (err_cnt_q == '0);
   assign bus.vec_cnt       = vec_cnt_q;
   assign bus.err_cnt       = err_cnt_q;
   assign bus.first_err_vld = first_err_vld_q;
   assign bus.first_err_vec = first_err_vec_q;

endmodule
